// File: rtl/w0rm_charlcd_4bit_responder.sv
// HD44780-style LCD-side responder for the 4-bit/8-bit character-LCD bus with busy flag, AC and byte forwarding.
// Optional DDRAM model enabled by defining W0RM_CHARLCD_RESP_DDRAM_EN.
module w0rm_charlcd_4bit_responder #(
  parameter int BUSY_CYCLES  = 37,
  parameter int CLEAR_CYCLES = 1520
) (
  input  logic       mem_clk,
  input  logic       cpu_reset_n,
  input  logic       lcd_bus_data_select,
  input  logic       lcd_bus_read_write,
  input  logic       lcd_bus_async_enable,
  input  logic [3:0] lcd_bus_data_i,
  output logic [3:0] lcd_bus_data_o,
  output logic       lcd_bus_data_oe,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_is_data,
  output logic [7:0] out_byte,
  output logic       busy,
  output logic [6:0] addr_counter,
  output logic [2:0] err_flags,
  input  logic       err_clear
);

  localparam int CW = $clog2(CLEAR_CYCLES + 1);
  localparam logic [CW-1:0] BUSY_LD  = CW'(BUSY_CYCLES);
  localparam logic [CW-1:0] CLEAR_LD = CW'(CLEAR_CYCLES);

  logic [1:0] rs_q, rw_q, e_q;
  logic [3:0] db_q1, db_q2;
  logic       e_d;
  logic       rs_s, rw_s, e_s;
  logic       rs_hold, rw_hold;
  logic [3:0] db_hold;

  logic       mode_8bit, phase, inc_mode;
  logic       rs_lat, rw_lat;
  logic [3:0] hi_nib;
  logic [7:0] rd_byte;
  logic [7:0] rd_data;
  logic [CW-1:0] busy_cnt;

  logic       e_fall, e_rise;
  logic       byte_done, split_err, wr_ok;
  logic [7:0] cmp_byte;
  logic       cmp_rs, cmp_rw;
  logic [6:0] ac_step;

  assign rs_s = rs_q[1];
  assign rw_s = rw_q[1];
  assign e_s  = e_q[1];

  always_ff @(posedge mem_clk or negedge cpu_reset_n) begin
    if (!cpu_reset_n) begin
      rs_q    <= '0;
      rw_q    <= '0;
      e_q     <= '0;
      db_q1   <= '0;
      db_q2   <= '0;
      e_d     <= 1'b0;
      rs_hold <= 1'b0;
      rw_hold <= 1'b0;
      db_hold <= '0;
    end else begin
      rs_q  <= {rs_q[0], lcd_bus_data_select};
      rw_q  <= {rw_q[0], lcd_bus_read_write};
      e_q   <= {e_q[0], lcd_bus_async_enable};
      db_q1 <= lcd_bus_data_i;
      db_q2 <= db_q1;
      e_d   <= e_s;
      // Freeze bus fields at the last cycle E was high so a fast host release cannot corrupt them.
      if (e_s) begin
        rs_hold <= rs_s;
        rw_hold <= rw_s;
        db_hold <= db_q2;
      end
    end
  end

  assign e_fall  = e_d & ~e_s;
  assign e_rise  = ~e_d & e_s;
  assign ac_step = inc_mode ? addr_counter + 7'd1 : addr_counter - 7'd1;

  always_comb begin
    byte_done = 1'b0;
    split_err = 1'b0;
    cmp_byte  = {db_hold, 4'h0};
    cmp_rs    = rs_hold;
    cmp_rw    = rw_hold;
    if (e_fall) begin
      if (mode_8bit) begin
        byte_done = 1'b1;
      end else if (phase) begin
        if ((rs_hold != rs_lat) || (rw_hold != rw_lat)) begin
          split_err = 1'b1;
        end else begin
          byte_done = 1'b1;
          cmp_byte  = {hi_nib, db_hold};
        end
      end
    end
  end

  assign wr_ok = byte_done & ~cmp_rw & ~busy;

  always_ff @(posedge mem_clk or negedge cpu_reset_n) begin
    if (!cpu_reset_n) begin
      mode_8bit    <= 1'b1;
      phase        <= 1'b0;
      inc_mode     <= 1'b1;
      rs_lat       <= 1'b0;
      rw_lat       <= 1'b0;
      hi_nib       <= '0;
      rd_byte      <= '0;
      busy_cnt     <= '0;
      busy         <= 1'b0;
      addr_counter <= '0;
      out_valid    <= 1'b0;
      out_is_data  <= 1'b0;
      out_byte     <= '0;
      err_flags    <= '0;
    end else begin
      if (err_clear) err_flags <= '0;
      if (out_valid && out_ready) out_valid <= 1'b0;

      if (busy) begin
        busy_cnt <= busy_cnt - 1'b1;
        if (busy_cnt == CW'(1)) busy <= 1'b0;
      end

      if (e_rise && rw_s && !phase) rd_byte <= rs_s ? rd_data : {busy, addr_counter};

      if (e_fall && !mode_8bit && !phase) begin
        phase  <= 1'b1;
        hi_nib <= db_hold;
        rs_lat <= rs_hold;
        rw_lat <= rw_hold;
      end

      if (split_err) begin
        err_flags[0] <= 1'b1;
        phase        <= 1'b0;
      end

      if (byte_done) phase <= 1'b0;
      if (byte_done && cmp_rw && cmp_rs) addr_counter <= ac_step;
      if (byte_done && !cmp_rw && busy) err_flags[1] <= 1'b1;

      if (wr_ok) begin
        busy     <= 1'b1;
        busy_cnt <= BUSY_LD;
        if (cmp_rs) begin
          addr_counter <= ac_step;
        end else begin
          casez (cmp_byte)
            8'b0000_0001: begin
              addr_counter <= '0;
              inc_mode     <= 1'b1;
              busy_cnt     <= CLEAR_LD;
            end
            8'b0000_001?: begin
              addr_counter <= '0;
              busy_cnt     <= CLEAR_LD;
            end
            8'b0000_01??: inc_mode <= cmp_byte[1];
            8'b001?_????: begin
              mode_8bit <= cmp_byte[4];
              phase     <= 1'b0;
            end
            8'b1???_????: addr_counter <= cmp_byte[6:0];
            default: ;
          endcase
        end
        // A held byte is never replaced, even if it is being accepted this same cycle.
        if (out_valid) begin
          err_flags[2] <= 1'b1;
        end else begin
          out_valid   <= 1'b1;
          out_byte    <= cmp_byte;
          out_is_data <= cmp_rs;
        end
      end
    end
  end

  assign lcd_bus_data_oe = rw_s & e_s;
  assign lcd_bus_data_o  = phase ? rd_byte[3:0] : rd_byte[7:4];

`ifdef W0RM_CHARLCD_RESP_DDRAM_EN
  logic [7:0] ddram [128];
  logic       fill_active;
  logic [6:0] fill_addr;

  always_ff @(posedge mem_clk or negedge cpu_reset_n) begin
    if (!cpu_reset_n) begin
      fill_active <= 1'b0;
      fill_addr   <= '0;
    end else if (wr_ok && !cmp_rs && cmp_byte == 8'h01) begin
      fill_active <= 1'b1;
      fill_addr   <= '0;
    end else if (fill_active) begin
      fill_addr <= fill_addr + 7'd1;
      if (fill_addr == 7'h7F) fill_active <= 1'b0;
    end
  end

  // Data writes cannot collide with the fill: they are rejected while the clear keeps BF set.
  always_ff @(posedge mem_clk) begin
    if (fill_active) ddram[fill_addr] <= 8'h20;
    else if (wr_ok && cmp_rs) ddram[addr_counter] <= cmp_byte;
  end

  assign rd_data = ddram[addr_counter];
`else
  assign rd_data = 8'h00;
`endif

endmodule

// File: tb/tb_w0rm_charlcd_4bit_responder.sv
// Directed bench for w0rm_charlcd_4bit_responder: vector table of 4-bit writes plus hand-written corner sequences.
module tb_w0rm_charlcd_4bit_responder;

  logic       mem_clk = 1'b0;
  logic       cpu_reset_n;
  logic       rs, rw, e;
  logic [3:0] db_i;
  logic [3:0] db_o;
  logic       db_oe;
  logic       out_valid, out_ready, out_is_data;
  logic [7:0] out_byte;
  logic       busy;
  logic [6:0] ac;
  logic [2:0] err;
  logic       err_clear;

  int errors = 0;
  int checks = 0;

  always #5 mem_clk = ~mem_clk;

  w0rm_charlcd_4bit_responder dut (
    .mem_clk              (mem_clk),
    .cpu_reset_n          (cpu_reset_n),
    .lcd_bus_data_select  (rs),
    .lcd_bus_read_write   (rw),
    .lcd_bus_async_enable (e),
    .lcd_bus_data_i       (db_i),
    .lcd_bus_data_o       (db_o),
    .lcd_bus_data_oe      (db_oe),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .out_is_data          (out_is_data),
    .out_byte             (out_byte),
    .busy                 (busy),
    .addr_counter         (ac),
    .err_flags            (err),
    .err_clear            (err_clear)
  );

  typedef struct {
    logic       rs;
    logic [7:0] b;
    logic       exp_data;
    logic [6:0] exp_ac;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one E pulse; returns on the negedge where E is dropped.
  task automatic send_nib(input logic r_s, input logic r_w, input logic [3:0] nib);
    @(negedge mem_clk);
    rs = r_s; rw = r_w; db_i = nib;
    repeat (2) @(negedge mem_clk);
    e = 1'b1;
    repeat (4) @(negedge mem_clk);
    e = 1'b0;
  endtask

  task automatic send_byte(input logic r_s, input logic [7:0] b);
    send_nib(r_s, 1'b0, b[7:4]);
    repeat (3) @(negedge mem_clk);
    send_nib(r_s, 1'b0, b[3:0]);
    repeat (4) @(negedge mem_clk);
  endtask

  task automatic read_nib(input logic r_s, input logic [3:0] exp_nib, input string name);
    @(negedge mem_clk);
    rs = r_s; rw = 1'b1;
    repeat (2) @(negedge mem_clk);
    e = 1'b1;
    repeat (3) @(negedge mem_clk);
    check({name, "_data"}, db_o, exp_nib);
    check({name, "_oe_hi"}, db_oe, 1'b1);
    e = 1'b0;
    repeat (3) @(negedge mem_clk);
    check({name, "_oe_lo"}, db_oe, 1'b0);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000 && busy; i++) @(negedge mem_clk);
    check("wait_idle_timeout", busy, 1'b0);
  endtask

  task automatic accept();
    @(negedge mem_clk);
    out_ready = 1'b1;
    @(negedge mem_clk);
    out_ready = 1'b0;
    check("accept_clears_valid", out_valid, 1'b0);
  endtask

  task automatic pulse_err_clear();
    @(negedge mem_clk);
    err_clear = 1'b1;
    @(negedge mem_clk);
    err_clear = 1'b0;
    check("err_clear", err, 3'b000);
  endtask

  initial begin
    logic [7:0] exp_rd;
    int         bcnt;

    tbl[0]  = '{1'b1, 8'h41, 1'b1, 7'h01};
    tbl[1]  = '{1'b0, 8'h06, 1'b0, 7'h01};
    tbl[2]  = '{1'b0, 8'hFF, 1'b0, 7'h7F};
    tbl[3]  = '{1'b1, 8'h42, 1'b1, 7'h00};
    tbl[4]  = '{1'b0, 8'h04, 1'b0, 7'h00};
    tbl[5]  = '{1'b1, 8'h43, 1'b1, 7'h7F};
    tbl[6]  = '{1'b1, 8'h44, 1'b1, 7'h7E};
    tbl[7]  = '{1'b0, 8'h0C, 1'b0, 7'h7E};
    tbl[8]  = '{1'b0, 8'h85, 1'b0, 7'h05};
    tbl[9]  = '{1'b0, 8'h06, 1'b0, 7'h05};
    tbl[10] = '{1'b1, 8'h45, 1'b1, 7'h06};
    tbl[11] = '{1'b0, 8'h02, 1'b0, 7'h00};

    cpu_reset_n = 1'b0;
    rs = 0; rw = 0; e = 0; db_i = 4'h0;
    out_ready = 1'b0; err_clear = 1'b0;
    repeat (3) @(negedge mem_clk);
    check("rst_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ac", ac, 7'h00);
    check("rst_err", err, 3'b000);
    check("rst_oe", db_oe, 1'b0);
    check("rst_data_o", db_o, 4'h0);
    cpu_reset_n = 1'b1;
    repeat (2) @(negedge mem_clk);

    // 8-bit function set to 4-bit mode, with latency and busy length
    send_nib(1'b0, 1'b0, 4'h2);
    repeat (2) @(negedge mem_clk);
    check("latency_2", out_valid, 1'b0);
    @(negedge mem_clk);
    check("latency_3", out_valid, 1'b1);
    check("fs_byte", out_byte, 8'h20);
    check("fs_is_data", out_is_data, 1'b0);
    bcnt = 0;
    while (busy && bcnt < 200) begin
      bcnt++;
      @(negedge mem_clk);
    end
    check("busy_cycles", bcnt, 37);
    accept();

    foreach (tbl[i]) begin
      send_byte(tbl[i].rs, tbl[i].b);
      check($sformatf("vec%0d_valid", i), out_valid, 1'b1);
      check($sformatf("vec%0d_byte", i), out_byte, tbl[i].b);
      check($sformatf("vec%0d_is_data", i), out_is_data, tbl[i].exp_data);
      check($sformatf("vec%0d_ac", i), ac, tbl[i].exp_ac);
      wait_idle();
      accept();
    end

    // Status read while clear keeps BF set, then a data read
    send_byte(1'b0, 8'h01);
    check("clr_byte", out_byte, 8'h01);
    accept();
    read_nib(1'b0, 4'h8, "st_hi");
    read_nib(1'b0, 4'h0, "st_lo");
    check("st_no_valid", out_valid, 1'b0);
    check("st_busy", busy, 1'b1);
`ifdef W0RM_CHARLCD_RESP_DDRAM_EN
    exp_rd = 8'h20;
`else
    exp_rd = 8'h00;
`endif
    read_nib(1'b1, exp_rd[7:4], "dr_hi");
    read_nib(1'b1, exp_rd[3:0], "dr_lo");
    check("dr_ac", ac, 7'h01);
    check("dr_no_valid", out_valid, 1'b0);

    // Overflow: second byte while first is still held
    wait_idle();
    send_byte(1'b1, 8'h50);
    wait_idle();
    send_byte(1'b1, 8'h51);
    check("ovf_held", out_byte, 8'h50);
    check("ovf_err", err, 3'b100);
    check("ovf_ac", ac, 7'h03);
    pulse_err_clear();
    accept();

    // Write while busy is dropped
    wait_idle();
    send_byte(1'b1, 8'h60);
    send_byte(1'b1, 8'h61);
    check("bw_err", err, 3'b010);
    check("bw_ac", ac, 7'h04);
    check("bw_byte", out_byte, 8'h60);
    pulse_err_clear();
    accept();

    // RS changes between nibbles
    wait_idle();
    send_nib(1'b1, 1'b0, 4'h4);
    repeat (3) @(negedge mem_clk);
    send_nib(1'b0, 1'b0, 4'h1);
    repeat (5) @(negedge mem_clk);
    check("split_no_valid", out_valid, 1'b0);
    check("split_err", err, 3'b001);
    pulse_err_clear();
    send_byte(1'b1, 8'h4A);
    check("post_split_byte", out_byte, 8'h4A);
    check("post_split_data", out_is_data, 1'b1);
    check("post_split_ac", ac, 7'h05);
    accept();

    // Back to 8-bit mode
    wait_idle();
    send_byte(1'b0, 8'h30);
    accept();
    wait_idle();
    send_nib(1'b1, 1'b0, 4'h7);
    repeat (4) @(negedge mem_clk);
    check("m8_byte", out_byte, 8'h70);
    check("m8_data", out_is_data, 1'b1);
    check("m8_ac", ac, 7'h06);

    // Reset while busy with a byte pending
    @(negedge mem_clk);
    cpu_reset_n = 1'b0;
    @(negedge mem_clk);
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_ac", ac, 7'h00);
    cpu_reset_n = 1'b1;
    repeat (2) @(negedge mem_clk);
    send_nib(1'b0, 1'b0, 4'h9);
    repeat (4) @(negedge mem_clk);
    check("post_rst_valid", out_valid, 1'b1);
    check("post_rst_byte", out_byte, 8'h90);
    check("post_rst_ac", ac, 7'h10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
